rv32i_dmem_responder: RTL and testbench

- Data-memory responder serving the RV32I core's load/store port; the core is the initiator, this block is the target.
- Accepts one request at a time over a valid/ready handshake.
- Applies configurable wait states, performs byte/half/word access with RV32I sign/zero extension, and returns the result over a second valid/ready handshake.
- Flags misaligned, out-of-range and illegal-funct3 accesses through rsp_err.

---
 rtl/rv32i_pkg.sv | 38 +++
 rtl/rv32i_dmem_responder_if.sv | 24 ++
 rtl/rv32i_lsu_align.sv | 55 +++++
 rtl/rv32i_dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, the data-memory
// responder state type and the access-size decode used by the lane aligner.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_e;

    function automatic acc_size_e size_decode(input logic [2:0] funct3);
        acc_size_e size;
        case (funct3[1:0])
            2'b00:   size = SZ_BYTE;
            2'b01:   size = SZ_HALF;
            2'b10:   size = SZ_WORD;
            default: size = SZ_NONE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// Load/store request and response channels between the core (master) and
// the data-memory responder (slave).
interface rv32i_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rv32i_lsu_align.sv
// Combinational lane steering for RV32I loads/stores: byte enables, replicated
// write data, sign/zero-extended read data and the misalignment flag.
module rv32i_lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    acc_size_e   size_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign size_s = size_decode(funct3);
    assign byte_s = rword[{addr_lo, 3'b000} +: 8];
    assign half_s = rword[{addr_lo[1], 4'b0000} +: 16];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'd0;
        rdata_ext  = 32'd0;
        misalign   = 1'b0;
        case (size_s)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = funct3[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SZ_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
                misalign   = addr_lo[0];
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
                misalign   = (addr_lo != 2'b00);
            end
            default: begin
                byte_en    = 4'b0000;
                wdata_lane = 32'd0;
                rdata_ext  = 32'd0;
                misalign   = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/rv32i_dmem_responder.sv
// RV32I data-memory target: one request at a time, WAIT_STATES extra cycles,
// access committed on entry to RESP, faults reported through rsp_err.
module rv32i_dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rv32i_dmem_responder_if.slave bus
);
    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic       HAS_WAIT  = (WAIT_STATES > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r, wdata_r;
    logic        req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic        req_ready_next_s, rsp_valid_next_s, rsp_err_next_s;
    logic [31:0] rsp_rdata_next_s;

    logic        accept_s, commit_s, mem_we_s;
    logic        acc_we_s;
    logic [2:0]  acc_funct3_s;
    logic [31:0] acc_addr_s, acc_wdata_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0] rword_s, wdata_lane_s, rdata_ext_s;
    logic [3:0]  byte_en_s;
    logic        misalign_s, range_err_s, illegal_s, err_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

    assign accept_s = bus.req_valid & req_ready_r;

    // With no wait states the access commits on the accept edge, before the capture registers load.
    assign acc_we_s     = (state_r == IDLE) ? bus.req_we     : we_r;
    assign acc_funct3_s = (state_r == IDLE) ? bus.req_funct3 : funct3_r;
    assign acc_addr_s   = (state_r == IDLE) ? bus.req_addr   : addr_r;
    assign acc_wdata_s  = (state_r == IDLE) ? bus.req_wdata  : wdata_r;

    assign idx_s       = acc_addr_s[IDX_W+1:2];
    assign range_err_s = |acc_addr_s[31:IDX_W+2];
    assign illegal_s   = acc_we_s ? !(acc_funct3_s inside {F3_SB, F3_SH, F3_SW})
                                  : !(acc_funct3_s inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    assign err_s       = misalign_s | range_err_s | illegal_s;
    assign rword_s     = mem_r[idx_s];
    assign commit_s    = (state_next_s == RESP) && (state_r != RESP);
    assign mem_we_s    = commit_s & acc_we_s & ~err_s & reset_n;

    rv32i_lsu_align u_align (
        .funct3     (acc_funct3_s),
        .addr_lo    (acc_addr_s[1:0]),
        .wdata      (acc_wdata_s),
        .rword      (rword_s),
        .byte_en    (byte_en_s),
        .wdata_lane (wdata_lane_s),
        .rdata_ext  (rdata_ext_s),
        .misalign   (misalign_s)
    );

    // State, wait counter, captured request and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                we_r     <= bus.req_we;
                funct3_r <= bus.req_funct3;
                addr_r   <= bus.req_addr;
                wdata_r  <= bus.req_wdata;
            end
            req_ready_r <= req_ready_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            rsp_rdata_r <= rsp_rdata_next_s;
            rsp_err_r   <= rsp_err_next_s;
        end
    end

    // Next-state and wait-counter decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (HAS_WAIT) begin
                        state_next_s = WAIT;
                        cnt_next_s   = WAIT_LOAD;
                    end else begin
                        state_next_s = RESP;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Next values of the registered outputs; response data is latched only at commit.
    always_comb begin
        req_ready_next_s = (state_next_s == IDLE);
        rsp_valid_next_s = (state_next_s == RESP);
        if (commit_s) begin
            rsp_err_next_s   = err_s;
            rsp_rdata_next_s = (err_s || acc_we_s) ? 32'd0 : rdata_ext_s;
        end else begin
            rsp_err_next_s   = rsp_err_r;
            rsp_rdata_next_s = rsp_rdata_r;
        end
    end

    // Byte-enabled storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_lane_s[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Randomized + directed bench for rv32i_dmem_responder against a byte-array
// reference model with a per-cycle output compare.
module tb_rv32i_dmem_responder;
    import rv32i_pkg::*;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    rv32i_dmem_responder_if bus();

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic        chk_en        = 1'b0;
    logic        exp_req_ready = 1'b1;
    logic        exp_rsp_valid = 1'b0;
    logic        exp_err       = 1'b0;
    logic [31:0] exp_rdata     = 32'd0;
    logic [7:0]  mem_b [DEPTH*4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: memory as bytes, legality and alignment from plain arithmetic.
    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int          nb;
        logic [31:0] v;
        logic        legal;
        nb    = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || ((addr % 32'(nb)) != 32'd0) || ((addr >> 2) >= 32'(DEPTH));
        rd    = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mem_b[addr + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | ({24'd0, mem_b[addr + 32'(i)]} << (8*i));
                if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    task automatic junk_inputs(input logic allow_valid);
        bus.req_valid  = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    // One transaction starting in an IDLE cycle; expectations are set per cycle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int bp,
                          output logic [31:0] got_rd, output logic got_err);
        logic [31:0] m_rd;
        logic        m_err;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = 1'($urandom_range(0, 1));
        exp_req_ready  = 1'b1;
        exp_rsp_valid  = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < WS; i++) begin
            junk_inputs(1'b1);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            exp_req_ready = 1'b0;
            exp_rsp_valid = 1'b0;
            @(posedge clk); #1;
        end
        model_access(we, f3, addr, wd, m_rd, m_err);
        exp_req_ready = 1'b0;
        exp_rsp_valid = 1'b1;
        exp_rdata     = m_rd;
        exp_err       = m_err;
        for (int i = 0; i < bp; i++) begin
            junk_inputs(1'b1);
            bus.rsp_ready = 1'b0;
            @(posedge clk); #1;
        end
        got_rd  = bus.rsp_rdata;
        got_err = bus.rsp_err;
        junk_inputs(1'b0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_req_ready = 1'b1;
        exp_rsp_valid = 1'b0;
    endtask

    task automatic dchk(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int bp,
                        input logic [31:0] want_rd, input logic want_err);
        logic [31:0] rd;
        logic        er;
        do_req(we, f3, addr, wd, bp, rd, er);
        check({name, "_rdata"}, rd, want_rd);
        check({name, "_err"}, 32'(er), 32'(want_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            junk_inputs(1'b0);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Per-cycle compare of the DUT against the current expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(exp_req_ready));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                check("rsp_rdata", bus.rsp_rdata, exp_rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          bp;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        for (int w = 0; w < 32; w++) do_req(1'b1, F3_SW, 32'(w * 4), $urandom, 0, rd, er);

        dchk("sw10", 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        dchk("lw10", 1'b0, F3_LW, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        dchk("sw20", 1'b1, F3_SW, 32'h20, 32'h80FF7F01, 0, 32'h0, 1'b0);
        dchk("lb23", 1'b0, F3_LB, 32'h23, 32'h0, 0, 32'hFFFFFF80, 1'b0);
        dchk("lbu23", 1'b0, F3_LBU, 32'h23, 32'h0, 0, 32'h00000080, 1'b0);
        dchk("lh22", 1'b0, F3_LH, 32'h22, 32'h0, 0, 32'hFFFF80FF, 1'b0);
        dchk("lhu20", 1'b0, F3_LHU, 32'h20, 32'h0, 0, 32'h00007F01, 1'b0);
        dchk("sw20b", 1'b1, F3_SW, 32'h20, 32'h11223344, 0, 32'h0, 1'b0);
        dchk("sb21", 1'b1, F3_SB, 32'h21, 32'h000000AA, 0, 32'h0, 1'b0);
        dchk("lw20_sb", 1'b0, F3_LW, 32'h20, 32'h0, 0, 32'h1122AA44, 1'b0);
        dchk("sh22", 1'b1, F3_SH, 32'h22, 32'h00005566, 0, 32'h0, 1'b0);
        dchk("lw20_sh", 1'b0, F3_LW, 32'h20, 32'h0, 0, 32'h5566AA44, 1'b0);
        dchk("lw22_mis", 1'b0, F3_LW, 32'h22, 32'h0, 0, 32'h0, 1'b1);
        dchk("sw30", 1'b1, F3_SW, 32'h30, 32'hCAFEF00D, 0, 32'h0, 1'b0);
        dchk("sh31_mis", 1'b1, F3_SH, 32'h31, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
        dchk("lw30_keep", 1'b0, F3_LW, 32'h30, 32'h0, 0, 32'hCAFEF00D, 1'b0);
        dchk("lw400_range", 1'b0, F3_LW, 32'h400, 32'h0, 0, 32'h0, 1'b1);
        dchk("ld_f3_011", 1'b0, 3'b011, 32'h30, 32'h0, 0, 32'h0, 1'b1);
        dchk("sb_f3_100", 1'b1, 3'b100, 32'h30, 32'h0, 0, 32'h0, 1'b1);
        dchk("lw10_bp", 1'b0, F3_LW, 32'h10, 32'h0, 5, 32'hDEADBEEF, 1'b0);

        // Store cut off by reset while waiting must leave storage untouched.
        dchk("sw40", 1'b1, F3_SW, 32'h40, 32'h0BADF00D, 0, 32'h0, 1'b0);
        dchk("lw10_pre", 1'b0, F3_LW, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_SW;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h12345678;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk_en        = 1'b0;
        check("wait_req_ready", 32'(bus.req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("midrst_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n       = 1'b1;
        exp_req_ready = 1'b1;
        exp_rsp_valid = 1'b0;
        chk_en        = 1'b1;
        dchk("lw40_after_rst", 1'b0, F3_LW, 32'h40, 32'h0, 0, 32'h0BADF00D, 1'b0);

        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h400;
            else addr = 32'($urandom_range(0, 127));
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_req(we, f3, addr, $urandom, bp, rd, er);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
